// File: rtl/imm_decode_stage.sv
// -----------------------------------------------------------------------------
// imm_decode_stage
//
// Pipelined immediate decoder between fetch and register read. A 32-bit
// instruction accepted on the in_* stream is decoded combinationally into an
// XLEN-wide immediate, a format code and an illegal flag. The result is
// registered into a two-entry (main + skid) buffer, so a decode appears on the
// out_* stream one cycle after it is accepted, and one instruction per cycle
// can be accepted while the consumer keeps out_ready high.
//
// Optional feature: define IMM_DECODE_RVC_EN to decode 16-bit compressed
// words (C.ADDI, C.LI, C.LUI, C.LW, C.SW). Without it every compressed
// encoding is reported as illegal and no compressed decode logic is built.
//
// Parameters:
//   XLEN        datapath width, 32 or 64
//   ILEN        instruction width, fixed at 32
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   flush       synchronous flush, discards held entries and the current input
//   in_valid    input instruction valid
//   in_ready    stage can accept an instruction (registered)
//   in_inst     instruction word
//   out_valid   output entry valid (registered)
//   out_ready   consumer accepts the output entry
//   out_imm     decoded immediate (registered)
//   out_fmt     0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 CSR (registered)
//   out_illegal unsupported opcode or encoding (registered)
// -----------------------------------------------------------------------------
module imm_decode_stage #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned ILEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [ILEN-1:0] in_inst,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_illegal
);

   localparam int unsigned FMT_W = 3;

   localparam logic [FMT_W-1:0] FMT_NONE  = 3'd0;
   localparam logic [FMT_W-1:0] FMT_I     = 3'd1;
   localparam logic [FMT_W-1:0] FMT_S     = 3'd2;
   localparam logic [FMT_W-1:0] FMT_B     = 3'd3;
   localparam logic [FMT_W-1:0] FMT_U     = 3'd4;
   localparam logic [FMT_W-1:0] FMT_J     = 3'd5;
   localparam logic [FMT_W-1:0] FMT_SHAMT = 3'd6;
   localparam logic [FMT_W-1:0] FMT_CSR   = 3'd7;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_OP32   = 7'b0111011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic IS_RV64 = (XLEN == 64);

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic [FMT_W-1:0] fmt;
      logic             illegal;
   } entry_t;

   // ST_ONE: only main holds data; ST_FULL: main and skid both hold data
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   state_e state_q;
   state_e state_d;
   entry_t dec;
   entry_t main_q;
   entry_t skid_q;
   logic   accept;
   logic   consume;
   logic   load_main;
   logic   load_skid;
   logic   skid_to_main;
   logic   out_valid_d;
   logic   in_ready_d;
   logic   is_shift;

   assign accept   = in_valid && in_ready;
   assign consume  = out_valid && out_ready;
   assign is_shift = (in_inst[14:12] == 3'b001) || (in_inst[14:12] == 3'b101);

   // Combinational decode of the presented instruction
   always_comb begin
      dec         = '0;
      dec.fmt     = FMT_NONE;
      dec.illegal = 1'b1;
      if (in_inst[1:0] == 2'b11) begin
         case (in_inst[6:0])
            OP_IMM: begin
               dec.illegal = 1'b0;
               if (is_shift) begin
                  dec.fmt = FMT_SHAMT;
                  if (IS_RV64) begin
                     dec.imm = XLEN'(in_inst[25:20]);
                  end else begin
                     // shamt[5] is reserved on RV32
                     dec.imm     = XLEN'(in_inst[24:20]);
                     dec.illegal = in_inst[25];
                  end
               end else begin
                  dec.fmt = FMT_I;
                  dec.imm = XLEN'($signed(in_inst[31:20]));
               end
            end
            OP_IMM32: begin
               if (IS_RV64) begin
                  dec.illegal = 1'b0;
                  if (is_shift) begin
                     dec.fmt = FMT_SHAMT;
                     dec.imm = XLEN'(in_inst[24:20]);
                  end else begin
                     dec.fmt = FMT_I;
                     dec.imm = XLEN'($signed(in_inst[31:20]));
                  end
               end
            end
            OP_LOAD, OP_JALR: begin
               dec.illegal = 1'b0;
               dec.fmt     = FMT_I;
               dec.imm     = XLEN'($signed(in_inst[31:20]));
            end
            OP_STORE: begin
               dec.illegal = 1'b0;
               dec.fmt     = FMT_S;
               dec.imm     = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
            end
            OP_BRANCH: begin
               dec.illegal = 1'b0;
               dec.fmt     = FMT_B;
               dec.imm     = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                            in_inst[11:8], 1'b0}));
            end
            OP_LUI, OP_AUIPC: begin
               dec.illegal = 1'b0;
               dec.fmt     = FMT_U;
               dec.imm     = XLEN'($signed({in_inst[31:12], 12'b0}));
            end
            OP_JAL: begin
               dec.illegal = 1'b0;
               dec.fmt     = FMT_J;
               dec.imm     = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                            in_inst[30:21], 1'b0}));
            end
            OP_SYSTEM: begin
               dec.illegal = 1'b0;
               dec.fmt     = FMT_CSR;
               dec.imm     = XLEN'(in_inst[31:20]);
            end
            OP_OP, OP_FENCE: begin
               dec.illegal = 1'b0;
            end
            OP_OP32: begin
               dec.illegal = !IS_RV64;
            end
            default: begin
               dec.illegal = 1'b1;
            end
         endcase
      end
`ifdef IMM_DECODE_RVC_EN
      else begin
         // Compressed word: quadrant in [1:0], funct3 in [15:13]
         case ({in_inst[1:0], in_inst[15:13]})
            {2'b01, 3'b000}, {2'b01, 3'b010}: begin
               dec.illegal = 1'b0;
               dec.fmt     = FMT_I;
               dec.imm     = XLEN'($signed({in_inst[12], in_inst[6:2]}));
            end
            {2'b01, 3'b011}: begin
               // rd=2 is C.ADDI16SP and rd=0 is reserved; neither is C.LUI
               if ((in_inst[11:7] != 5'd0) && (in_inst[11:7] != 5'd2)) begin
                  dec.illegal = 1'b0;
                  dec.fmt     = FMT_U;
                  dec.imm     = XLEN'($signed({in_inst[12], in_inst[6:2], 12'b0}));
               end
            end
            {2'b00, 3'b010}: begin
               dec.illegal = 1'b0;
               dec.fmt     = FMT_I;
               dec.imm     = XLEN'({in_inst[5], in_inst[12:10], in_inst[6], 2'b00});
            end
            {2'b00, 3'b110}: begin
               dec.illegal = 1'b0;
               dec.fmt     = FMT_S;
               dec.imm     = XLEN'({in_inst[5], in_inst[12:10], in_inst[6], 2'b00});
            end
            default: begin
               dec.illegal = 1'b1;
            end
         endcase
      end
`endif
   end

   // Buffer occupancy: next state and entry-move controls
   always_comb begin
      state_d      = state_q;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
      out_valid_d  = 1'b0;
      in_ready_d   = 1'b1;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d   = ST_ONE;
               load_main = 1'b1;
            end
         end
         ST_ONE: begin
            if (accept && consume) begin
               load_main = 1'b1;
            end else if (accept) begin
               state_d   = ST_FULL;
               load_skid = 1'b1;
            end else if (consume) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // in_ready is low here, so only a consume can happen
            if (consume) begin
               state_d      = ST_ONE;
               skid_to_main = 1'b1;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
      if (flush) begin
         state_d      = ST_EMPTY;
         load_main    = 1'b0;
         load_skid    = 1'b0;
         skid_to_main = 1'b0;
      end
      out_valid_d = (state_d != ST_EMPTY);
      in_ready_d  = (state_d != ST_FULL);
   end

   // State and handshake registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         state_q   <= state_d;
         out_valid <= out_valid_d;
         in_ready  <= in_ready_d;
      end
   end

   // Entry data registers; left untouched by flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main) begin
            main_q <= dec;
         end else if (skid_to_main) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= dec;
         end
      end
   end

   assign out_imm     = main_q.imm;
   assign out_fmt     = main_q.fmt;
   assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_imm_decode_stage
//
// Directed bench for imm_decode_stage. An XLEN=32 and an XLEN=64 instance
// share the same stimulus; handshake behaviour is checked on the 32-bit
// instance and decode results on both. Inputs change and outputs are sampled
// on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_imm_decode_stage;

   localparam int unsigned XLEN32 = 32;
   localparam int unsigned XLEN64 = 64;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] imm32;
      logic [2:0]  fmt32;
      logic        ill32;
      logic [63:0] imm64;
      logic [2:0]  fmt64;
      logic        ill64;
   } vec_t;

   logic              clk;
   logic              rst_n;
   logic              flush;
   logic              in_valid;
   logic [31:0]       in_inst;
   logic              out_ready;

   logic              in_ready;
   logic              out_valid;
   logic [XLEN32-1:0] out_imm;
   logic [2:0]        out_fmt;
   logic              out_illegal;

   logic              in_ready64;
   logic              out_valid64;
   logic [XLEN64-1:0] out_imm64;
   logic [2:0]        out_fmt64;
   logic              out_illegal64;

   int vectors;
   int miscompares;

   imm_decode_stage #(.XLEN(XLEN32), .ILEN(32)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_inst     (in_inst),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_imm     (out_imm),
      .out_fmt     (out_fmt),
      .out_illegal (out_illegal)
   );

   imm_decode_stage #(.XLEN(XLEN64), .ILEN(32)) u_dut64 (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready64),
      .in_inst     (in_inst),
      .out_valid   (out_valid64),
      .out_ready   (out_ready),
      .out_imm     (out_imm64),
      .out_fmt     (out_fmt64),
      .out_illegal (out_illegal64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_inst   = 32'h0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({out_valid, in_ready, out_imm, out_fmt, out_illegal} !== {1'b0, 1'b1, 32'h0, 3'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset: got valid=%b ready=%b imm=%h fmt=%0d ill=%b, want 0 1 0 0 0",
                  out_valid, in_ready, out_imm, out_fmt, out_illegal);
      end
      vectors++;
      if ({out_valid64, in_ready64, out_imm64} !== {1'b0, 1'b1, 64'h0}) begin
         miscompares++;
         $display("FAIL reset64: got valid=%b ready=%b imm=%h, want 0 1 0",
                  out_valid64, in_ready64, out_imm64);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_decode();
      vec_t vq[$];
      vq.push_back('{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0}); // addi -1
      vq.push_back('{32'h4030D093, 32'h00000003, 3'd6, 1'b0, 64'h3,                3'd6, 1'b0}); // srai 3
      vq.push_back('{32'h4230D093, 32'h00000003, 3'd6, 1'b1, 64'h23,               3'd6, 1'b0}); // shamt[5]
      vq.push_back('{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0}); // beq -4
      vq.push_back('{32'h00112423, 32'h00000008, 3'd2, 1'b0, 64'h8,                3'd2, 1'b0}); // sw 8
      vq.push_back('{32'hFE112FA3, 32'hFFFFFFFF, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd2, 1'b0}); // sw -1
      vq.push_back('{32'h123452B7, 32'h12345000, 3'd4, 1'b0, 64'h12345000,         3'd4, 1'b0}); // lui
      vq.push_back('{32'h800002B7, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0}); // lui top bit
      vq.push_back('{32'h001000EF, 32'h00000800, 3'd5, 1'b0, 64'h800,              3'd5, 1'b0}); // jal 2048
      vq.push_back('{32'hFFF01073, 32'h00000FFF, 3'd7, 1'b0, 64'hFFF,              3'd7, 1'b0}); // csrrw 0xfff
      vq.push_back('{32'h003100B3, 32'h00000000, 3'd0, 1'b0, 64'h0,                3'd0, 1'b0}); // add
      vq.push_back('{32'hFFFFFFFF, 32'h00000000, 3'd0, 1'b1, 64'h0,                3'd0, 1'b1}); // bad opcode
      vq.push_back('{32'h0010809B, 32'h00000000, 3'd0, 1'b1, 64'h1,                3'd1, 1'b0}); // addiw 1
      vq.push_back('{32'h0010909B, 32'h00000000, 3'd0, 1'b1, 64'h1,                3'd6, 1'b0}); // slliw 1
      vq.push_back('{32'h003100BB, 32'h00000000, 3'd0, 1'b1, 64'h0,                3'd0, 1'b0}); // addw
`ifdef IMM_DECODE_RVC_EN
      vq.push_back('{32'h0000557D, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0}); // c.li -1
      vq.push_back('{32'h00004040, 32'h00000004, 3'd1, 1'b0, 64'h4,                3'd1, 1'b0}); // c.lw 4
      vq.push_back('{32'h0000DC60, 32'h0000007C, 3'd2, 1'b0, 64'h7C,               3'd2, 1'b0}); // c.sw 124
      vq.push_back('{32'h000071FD, 32'hFFFFF000, 3'd4, 1'b0, 64'hFFFFFFFFFFFFF000, 3'd4, 1'b0}); // c.lui -1
`else
      vq.push_back('{32'h0000557D, 32'h0, 3'd0, 1'b1, 64'h0, 3'd0, 1'b1}); // c.li
      vq.push_back('{32'h00004040, 32'h0, 3'd0, 1'b1, 64'h0, 3'd0, 1'b1}); // c.lw
      vq.push_back('{32'h0000DC60, 32'h0, 3'd0, 1'b1, 64'h0, 3'd0, 1'b1}); // c.sw
      vq.push_back('{32'h000071FD, 32'h0, 3'd0, 1'b1, 64'h0, 3'd0, 1'b1}); // c.lui
`endif
      vq.push_back('{32'h0000717D, 32'h0, 3'd0, 1'b1, 64'h0, 3'd0, 1'b1}); // c.lui rd=2
      vq.push_back('{32'h00000002, 32'h0, 3'd0, 1'b1, 64'h0, 3'd0, 1'b1}); // quadrant 10

      out_ready = 1'b1;
      foreach (vq[i]) begin
         in_valid = 1'b1;
         in_inst  = vq[i].inst;
         @(negedge clk);
         in_valid = 1'b0;
         vectors++;
         if ({out_valid, out_imm, out_fmt, out_illegal} !== {1'b1, vq[i].imm32, vq[i].fmt32, vq[i].ill32}) begin
            miscompares++;
            $display("FAIL decode32 inst=%h: got valid=%b imm=%h fmt=%0d ill=%b, want 1 %h %0d %b",
                     vq[i].inst, out_valid, out_imm, out_fmt, out_illegal,
                     vq[i].imm32, vq[i].fmt32, vq[i].ill32);
         end
         vectors++;
         if ({out_valid64, out_imm64, out_fmt64, out_illegal64} !== {1'b1, vq[i].imm64, vq[i].fmt64, vq[i].ill64}) begin
            miscompares++;
            $display("FAIL decode64 inst=%h: got valid=%b imm=%h fmt=%0d ill=%b, want 1 %h %0d %b",
                     vq[i].inst, out_valid64, out_imm64, out_fmt64, out_illegal64,
                     vq[i].imm64, vq[i].fmt64, vq[i].ill64);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] insts [4];
      logic [31:0] imms  [4];
      insts = '{32'hFFF00093, 32'h00500093, 32'h123452B7, 32'hFE000EE3};
      imms  = '{32'hFFFFFFFF, 32'h00000005, 32'h12345000, 32'hFFFFFFFC};
      out_ready = 1'b1;
      for (int k = 0; k <= 4; k++) begin
         if (k >= 1) begin
            vectors++;
            if ({out_valid, in_ready, out_imm} !== {1'b1, 1'b1, imms[k-1]}) begin
               miscompares++;
               $display("FAIL b2b[%0d]: got valid=%b ready=%b imm=%h, want 1 1 %h",
                        k - 1, out_valid, in_ready, out_imm, imms[k-1]);
            end
         end
         if (k < 4) begin
            in_valid = 1'b1;
            in_inst  = insts[k];
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_drain: got valid=%b, want 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_inst   = 32'h00500093;          // A: addi x1,x0,5
      @(negedge clk);
      vectors++;
      if ({out_valid, in_ready, out_imm} !== {1'b1, 1'b1, 32'h5}) begin
         miscompares++;
         $display("FAIL bp_a: got valid=%b ready=%b imm=%h, want 1 1 00000005",
                  out_valid, in_ready, out_imm);
      end
      in_inst = 32'h123452B7;            // B: lui x5,0x12345
      @(negedge clk);
      in_inst = 32'h00700093;            // C: addi x1,x0,7, held while blocked
      for (int s = 0; s < 2; s++) begin
         vectors++;
         if ({out_valid, in_ready, out_imm, out_fmt, out_illegal} !== {1'b1, 1'b0, 32'h5, 3'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL bp_stall[%0d]: got valid=%b ready=%b imm=%h fmt=%0d ill=%b, want 1 0 00000005 1 0",
                     s, out_valid, in_ready, out_imm, out_fmt, out_illegal);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if ({out_valid, in_ready, out_imm, out_fmt} !== {1'b1, 1'b1, 32'h12345000, 3'd4}) begin
         miscompares++;
         $display("FAIL bp_b: got valid=%b ready=%b imm=%h fmt=%0d, want 1 1 12345000 4",
                  out_valid, in_ready, out_imm, out_fmt);
      end
      @(negedge clk);
      in_valid = 1'b0;
      vectors++;
      if ({out_valid, in_ready, out_imm} !== {1'b1, 1'b1, 32'h7}) begin
         miscompares++;
         $display("FAIL bp_c: got valid=%b ready=%b imm=%h, want 1 1 00000007",
                  out_valid, in_ready, out_imm);
      end
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_drain: got valid=%b, want 0", out_valid);
      end
   endtask

   task automatic test_flush();
      // Flush with both entries full
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_inst   = 32'h00500093;
      @(negedge clk);
      in_inst = 32'h123452B7;
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_full_ready: got ready=%b, want 0", in_ready);
      end
      flush   = 1'b1;
      in_inst = 32'h00700093;
      @(negedge clk);
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      vectors++;
      if ({out_valid, in_ready} !== 2'b01) begin
         miscompares++;
         $display("FAIL flush_full: got valid=%b ready=%b, want 0 1", out_valid, in_ready);
      end
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_full_quiet: got valid=%b, want 0", out_valid);
      end

      // Flush with one entry while an input is presented and accepted
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_inst   = 32'h00500093;
      @(negedge clk);
      flush   = 1'b1;
      in_inst = 32'h00700093;
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      vectors++;
      if ({out_valid, in_ready} !== 2'b01) begin
         miscompares++;
         $display("FAIL flush_one: got valid=%b ready=%b, want 0 1", out_valid, in_ready);
      end

      // Stage works normally afterwards
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_inst   = 32'h00900093;          // addi x1,x0,9
      @(negedge clk);
      in_valid = 1'b0;
      vectors++;
      if ({out_valid, out_imm} !== {1'b1, 32'h9}) begin
         miscompares++;
         $display("FAIL flush_after: got valid=%b imm=%h, want 1 00000009", out_valid, out_imm);
      end
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_inst   = 32'hFFF00093;
      @(negedge clk);
      in_inst = 32'h123452B7;
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({out_valid, in_ready, out_imm, out_fmt, out_illegal} !== {1'b0, 1'b1, 32'h0, 3'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL async_reset: got valid=%b ready=%b imm=%h fmt=%0d ill=%b, want 0 1 0 0 0",
                  out_valid, in_ready, out_imm, out_fmt, out_illegal);
      end
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if ({out_valid, in_ready} !== 2'b01) begin
         miscompares++;
         $display("FAIL async_reset_after: got valid=%b ready=%b, want 0 1", out_valid, in_ready);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_decode();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
